// File: rtl/matrix_mac_seq.sv
// matrix_mac_seq: sequential R x K by K x C integer matrix multiply-accumulate, one MAC per clock.
module matrix_mac_seq #(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int INNER = 4,
  parameter int COLS  = 4,
  parameter int ACC_W = 2*DW + $clog2(INNER)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sgn,
  input  logic                        acc,
  input  logic                        abort,
  input  logic [DW*ROWS*INNER-1:0]    in_A,
  input  logic [DW*INNER*COLS-1:0]    in_B,
  output logic [ACC_W*ROWS*COLS-1:0]  out_M,
  output logic                        busy,
  output logic                        done
);
  localparam int IW = ROWS  > 1 ? $clog2(ROWS)  : 1;
  localparam int JW = COLS  > 1 ? $clog2(COLS)  : 1;
  localparam int KW = INNER > 1 ? $clog2(INNER) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                     state_q, state_d;
  logic [IW-1:0]              i_q, i_d;
  logic [JW-1:0]              j_q, j_d;
  logic [KW-1:0]              k_q, k_d;
  logic [DW*ROWS*INNER-1:0]   a_q, a_d;
  logic [DW*INNER*COLS-1:0]   b_q, b_d;
  logic [ACC_W*ROWS*COLS-1:0] m_q, m_d;
  logic                       sgn_q, sgn_d, done_q, done_d;
  logic [DW-1:0]              a_el, b_el;
  logic signed [DW:0]         a_x, b_x;
  logic signed [ACC_W-1:0]    a_w, b_w, prod;
  logic                       last_i, last_j, last_k;
  int                         m_idx;
  always_comb begin
    a_el   = a_q[(int'(i_q)*INNER + int'(k_q))*DW +: DW];
    b_el   = b_q[(int'(k_q)*COLS + int'(j_q))*DW +: DW];
    a_x    = {sgn_q & a_el[DW-1], a_el};
    b_x    = {sgn_q & b_el[DW-1], b_el};
    a_w    = ACC_W'(a_x);
    b_w    = ACC_W'(b_x);
    // exact product fits in 2*DW bits, so multiplying the ACC_W-extended operands mod 2^ACC_W equals extending it
    prod   = a_w * b_w;
    m_idx  = int'(i_q)*COLS + int'(j_q);
    last_i = i_q == IW'(ROWS-1);
    last_j = j_q == JW'(COLS-1);
    last_k = k_q == KW'(INNER-1);
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    sgn_d  = sgn_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && !abort) begin
        state_d = RUN;
        a_d = in_A;
        b_d = in_B;
        sgn_d = sgn;
        m_d = acc ? m_q : '0;
      end
    end else if (abort) begin
      state_d = IDLE;
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else begin
      m_d[m_idx*ACC_W +: ACC_W] = m_q[m_idx*ACC_W +: ACC_W] + prod;
      k_d = last_k ? '0 : k_q + 1'b1;
      j_d = last_k ? (last_j ? '0 : j_q + 1'b1) : j_q;
      i_d = (last_k && last_j) ? (last_i ? '0 : i_q + 1'b1) : i_q;
      if (last_k && last_j && last_i) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      sgn_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      sgn_q <= sgn_d;
      done_q <= done_d;
    end
  end
  assign out_M = m_q;
  assign busy  = state_q == RUN;
  assign done  = done_q;
endmodule

// File: tb/tb_matrix_mac_seq.sv
// tb_matrix_mac_seq: directed checks of matrix_mac_seq with hand-computed results.
module tb_matrix_mac_seq;
  logic         clk = 1'b0, reset = 1'b1, start = 1'b0, sgn = 1'b0, acc = 1'b0, abort = 1'b0;
  logic [127:0] in_A = '0, in_B = '0;
  logic [287:0] out_M;
  logic         busy, done;
  int           n_chk = 0, n_pass = 0;

  matrix_mac_seq dut (
    .clk(clk), .reset(reset), .start(start), .sgn(sgn), .acc(acc), .abort(abort),
    .in_A(in_A), .in_B(in_B), .out_M(out_M), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic logic [31:0] m_at(input int i, input int j);
    return {14'd0, out_M[(i*4+j)*18 +: 18]};
  endfunction

  function automatic logic [127:0] ident_a();
    logic [127:0] v = '0;
    for (int i = 0; i < 4; i++) v[(i*4+i)*8 +: 8] = 8'd1;
    return v;
  endfunction

  function automatic logic [127:0] seq_b();
    logic [127:0] v = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) v[(k*4+j)*8 +: 8] = 8'(4*k + j + 1);
    return v;
  endfunction

  // called at a negedge; start is sampled at the next posedge (E0); returns at the negedge where done is seen
  task automatic run(input logic s, input logic a, output int lat, output int busy_cnt);
    sgn = s; acc = a; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; lat = 0; busy_cnt = 0;
    while (lat < 200 && !done) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_ident(input string tag, input int scale);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("%s_m%0d%0d", tag, i, j), m_at(i, j), 32'(scale*(4*i + j + 1)));
  endtask

  initial begin
    int lat, bc, dones;
    #2;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_m", {31'd0, out_M != '0}, 0);
    #10 reset = 1'b0;
    @(negedge clk);

    in_A = ident_a(); in_B = seq_b();
    run(1'b0, 1'b0, lat, bc);
    check("id_latency", lat, 64);
    check("id_busy_cycles", bc, 64);
    check("id_busy_in_done", {31'd0, busy}, 0);
    check_ident("id", 1);
    @(negedge clk);
    check("id_done_falls", {31'd0, done}, 0);

    in_A = {16{8'hFF}}; in_B = {16{8'h02}};
    run(1'b1, 1'b0, lat, bc);
    check("sgn_m00", m_at(0, 0), 32'h3FFF8);
    check("sgn_m33", m_at(3, 3), 32'h3FFF8);
    run(1'b0, 1'b0, lat, bc);
    check("uns_m00", m_at(0, 0), 2040);
    check("uns_m21", m_at(2, 1), 2040);

    in_A = ident_a(); in_B = seq_b();
    run(1'b0, 1'b0, lat, bc);
    run(1'b0, 1'b1, lat, bc);
    check("acc_b2b_latency", lat, 64);
    check_ident("acc2", 2);

    in_A = {16{8'hFF}}; in_B = {16{8'hFF}};
    run(1'b0, 1'b0, lat, bc);
    check("wrap1_m00", m_at(0, 0), 260100);
    for (int r = 0; r < 7; r++) run(1'b0, 1'b1, lat, bc);
    check("wrap8_m00", m_at(0, 0), 245792);
    check("wrap8_m33", m_at(3, 3), 245792);

    in_A = ident_a(); in_B = seq_b(); sgn = 1'b0; acc = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in_A = '0; dones = 0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("latch_dones", dones, 1);
    check_ident("latch", 1);

    in_A = ident_a(); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    check("abort_no_done", dones, 0);
    for (int j = 0; j < 4; j++) check($sformatf("abort_m0%0d", j), m_at(0, j), 32'(j + 1));
    check("abort_m10", m_at(1, 0), 5);
    check("abort_m11", m_at(1, 1), 0);
    run(1'b0, 1'b0, lat, bc);
    check("post_abort_latency", lat, 64);
    check_ident("post_abort", 1);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstrun_busy", {31'd0, busy}, 0);
    check("rstrun_done", {31'd0, done}, 0);
    check("rstrun_m", {31'd0, out_M != '0}, 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || done) dones++;
    end
    check("rstrun_idle", dones, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
